// File: rtl/fetch_sequencer.sv
// Fetch-stage controller: sequences instruction-memory program load, run-time fetch, stall and redirect flush.
// Latency: strobes are combinational from state and inputs; o_load_done is registered one cycle after the final word.
module fetch_sequencer #(
    parameter int MAX_WORDS    = 256,
    parameter int FLUSH_CYCLES = 1
) (
    input  logic                         i_clk,
    input  logic                         i_reset,
    input  logic                         i_load_start,
    input  logic                         i_run,
    input  logic                         i_halt,
    input  logic                         i_ld_valid,
    input  logic                         i_ld_last,
    input  logic [31:0]                  i_ld_data,
    output logic                         o_ld_ready,
    input  logic                         i_stall,
    input  logic                         i_branch,
    input  logic                         i_zero,
    input  logic                         i_jump,
    output logic                         o_pc_en,
    output logic                         o_ifid_en,
    output logic                         o_ifid_flush,
    output logic                         o_imem_read,
    output logic                         o_imem_write,
    output logic [31:0]                  o_imem_waddr,
    output logic [31:0]                  o_imem_wdata,
    output logic                         o_load_done,
    output logic [$clog2(MAX_WORDS):0]   o_word_count,
    output logic [2:0]                   o_state
);
    localparam int CW = $clog2(MAX_WORDS) + 1;
    localparam logic [CW-1:0] MAX_CNT      = CW'(MAX_WORDS);
    localparam logic [1:0]    FLUSH_RELOAD = 2'(FLUSH_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_LOAD     = 3'd1,
        S_RUN      = 3'd2,
        S_REDIRECT = 3'd3,
        S_HALT     = 3'd4
    } state_t;

    state_t        state, state_nxt;
    logic [CW-1:0] count, count_nxt;
    logic [1:0]    flush_cnt, flush_cnt_nxt;
    logic          load_done_q, load_done_nxt;
    logic          redirect, accept, at_limit;

    assign redirect     = (i_branch & i_zero) | i_jump;
    assign o_ld_ready   = (state == S_LOAD) && (count < MAX_CNT);
    assign accept       = i_ld_valid & o_ld_ready;
    assign at_limit     = (count == MAX_CNT - CW'(1));
    assign o_imem_write = accept;
    assign o_imem_waddr = 32'({count, 2'b00});
    assign o_imem_wdata = i_ld_data;
    assign o_load_done  = load_done_q;
    assign o_word_count = count;
    assign o_state      = state;

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            state       <= S_IDLE;
            count       <= '0;
            flush_cnt   <= '0;
            load_done_q <= 1'b0;
        end else begin
            state       <= state_nxt;
            count       <= count_nxt;
            flush_cnt   <= flush_cnt_nxt;
            load_done_q <= load_done_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        count_nxt     = count;
        flush_cnt_nxt = flush_cnt;
        load_done_nxt = 1'b0;
        o_pc_en       = 1'b0;
        o_ifid_en     = 1'b0;
        o_ifid_flush  = 1'b0;
        o_imem_read   = 1'b0;
        case (state)
            S_IDLE, S_HALT: begin
                if (i_load_start) begin
                    state_nxt = S_LOAD;
                    count_nxt = '0;
                end else if (i_run) begin
                    state_nxt = S_RUN;
                end
            end
            S_LOAD: begin
                if (accept) begin
                    count_nxt = count + CW'(1);
                    if (i_ld_last || at_limit) begin
                        state_nxt     = S_IDLE;
                        load_done_nxt = 1'b1;
                    end
                end
            end
            S_RUN: begin
                o_imem_read = 1'b1;
                if (i_halt) begin
                    state_nxt = S_HALT;
                end else if (redirect) begin
                    // PC loads the branch/jump target while the wrong-path fetch is squashed
                    o_pc_en      = 1'b1;
                    o_ifid_flush = 1'b1;
                    if (FLUSH_CYCLES > 1) begin
                        state_nxt     = S_REDIRECT;
                        flush_cnt_nxt = FLUSH_RELOAD;
                    end
                end else if (!i_stall) begin
                    o_pc_en   = 1'b1;
                    o_ifid_en = 1'b1;
                end
            end
            S_REDIRECT: begin
                o_imem_read = 1'b1;
                if (i_halt) begin
                    // halting abandons the remaining flush; nothing further enters IF/ID
                    state_nxt     = S_HALT;
                    flush_cnt_nxt = '0;
                end else begin
                    o_ifid_flush = 1'b1;
                    o_pc_en      = ~i_stall;
                    if (redirect) begin
                        flush_cnt_nxt = FLUSH_RELOAD;
                    end else if (flush_cnt <= 2'd1) begin
                        state_nxt     = S_RUN;
                        flush_cnt_nxt = '0;
                    end else begin
                        flush_cnt_nxt = flush_cnt - 2'd1;
                    end
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end
endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: default instance (256 words, 1 flush cycle) and a small one (4 words, 2 flush cycles).
module tb_fetch_sequencer;
    logic        i_clk = 1'b0;
    logic        i_reset, i_load_start, i_run, i_halt;
    logic        i_ld_valid, i_ld_last;
    logic [31:0] i_ld_data;
    logic        i_stall, i_branch, i_zero, i_jump;

    logic        a_ld_ready, a_pc_en, a_ifid_en, a_ifid_flush, a_imem_read, a_imem_write, a_load_done;
    logic [31:0] a_imem_waddr, a_imem_wdata;
    logic [8:0]  a_word_count;
    logic [2:0]  a_state;
    logic        b_ld_ready, b_pc_en, b_ifid_en, b_ifid_flush, b_imem_read, b_imem_write, b_load_done;
    logic [31:0] b_imem_waddr, b_imem_wdata;
    logic [2:0]  b_word_count;
    logic [2:0]  b_state;

    int pass_cnt = 0;
    int total_cnt = 0;
    logic [63:0] exp_q[$];
    logic [31:0] words [4] = '{32'h20080005, 32'h2009000C, 32'h200A0007, 32'hAC080000};

    always #5 i_clk = ~i_clk;

    fetch_sequencer dut_a (
        .i_clk(i_clk), .i_reset(i_reset), .i_load_start(i_load_start), .i_run(i_run), .i_halt(i_halt),
        .i_ld_valid(i_ld_valid), .i_ld_last(i_ld_last), .i_ld_data(i_ld_data), .o_ld_ready(a_ld_ready),
        .i_stall(i_stall), .i_branch(i_branch), .i_zero(i_zero), .i_jump(i_jump),
        .o_pc_en(a_pc_en), .o_ifid_en(a_ifid_en), .o_ifid_flush(a_ifid_flush), .o_imem_read(a_imem_read),
        .o_imem_write(a_imem_write), .o_imem_waddr(a_imem_waddr), .o_imem_wdata(a_imem_wdata),
        .o_load_done(a_load_done), .o_word_count(a_word_count), .o_state(a_state)
    );

    fetch_sequencer #(.MAX_WORDS(4), .FLUSH_CYCLES(2)) dut_b (
        .i_clk(i_clk), .i_reset(i_reset), .i_load_start(i_load_start), .i_run(i_run), .i_halt(i_halt),
        .i_ld_valid(i_ld_valid), .i_ld_last(i_ld_last), .i_ld_data(i_ld_data), .o_ld_ready(b_ld_ready),
        .i_stall(i_stall), .i_branch(i_branch), .i_zero(i_zero), .i_jump(i_jump),
        .o_pc_en(b_pc_en), .o_ifid_en(b_ifid_en), .o_ifid_flush(b_ifid_flush), .o_imem_read(b_imem_read),
        .o_imem_write(b_imem_write), .o_imem_waddr(b_imem_waddr), .o_imem_wdata(b_imem_wdata),
        .o_load_done(b_load_done), .o_word_count(b_word_count), .o_state(b_state)
    );

    task automatic clear_inputs();
        i_load_start = 0; i_run = 0; i_halt = 0; i_ld_valid = 0; i_ld_last = 0;
        i_ld_data = '0; i_stall = 0; i_branch = 0; i_zero = 0; i_jump = 0;
    endtask

    task automatic apply_reset();
        clear_inputs();
        i_reset = 0;
        repeat (2) @(posedge i_clk);
        #1 i_reset = 1;
    endtask

    // leaves both instances in RUN, at posedge+1
    task automatic enter_run();
        apply_reset();
        i_run = 1;
        @(posedge i_clk); #1 i_run = 0;
    endtask

    task automatic test_reset();
        clear_inputs();
        i_reset = 0;
        #2;
        total_cnt++; if ({a_state, b_state} !== 6'd0) $display("FAIL reset_state a=%0d b=%0d want 0", a_state, b_state); else pass_cnt++;
        total_cnt++;
        if ({a_ld_ready, a_pc_en, a_ifid_en, a_ifid_flush, a_imem_read, a_imem_write, a_load_done} !== 7'd0 || a_imem_waddr !== 32'd0)
            $display("FAIL reset_outputs strobes=%b waddr=%h want 0", {a_ld_ready, a_pc_en, a_ifid_en, a_ifid_flush, a_imem_read, a_imem_write, a_load_done}, a_imem_waddr);
        else pass_cnt++;
        // abort a load after three words
        apply_reset();
        i_load_start = 1;
        @(posedge i_clk); #1 i_load_start = 0;
        i_ld_valid = 1;
        for (int k = 0; k < 3; k++) begin
            i_ld_data = words[k];
            @(posedge i_clk); #1;
        end
        total_cnt++; if (a_word_count !== 9'd3) $display("FAIL reset_preload_count got %0d want 3", a_word_count); else pass_cnt++;
        #2 i_reset = 0;
        #1;
        total_cnt++; if (a_state !== 3'd0 || a_word_count !== 9'd0) $display("FAIL reset_midload state=%0d count=%0d want 0/0", a_state, a_word_count); else pass_cnt++;
        total_cnt++;
        if ({a_ld_ready, a_imem_write, a_pc_en, a_ifid_en, a_ifid_flush, a_imem_read, a_load_done} !== 7'd0)
            $display("FAIL reset_midload_strobes got %b want 0", {a_ld_ready, a_imem_write, a_pc_en, a_ifid_en, a_ifid_flush, a_imem_read, a_load_done});
        else pass_cnt++;
        clear_inputs();
        @(posedge i_clk); #1 i_reset = 1;
    endtask

    task automatic test_load();
        int  w = 0, done_seen = 0, writes = 0;
        bit  exp_wr;
        logic [63:0] e;
        apply_reset();
        exp_q.delete();
        i_load_start = 1;
        @(posedge i_clk); #1 i_load_start = 0;
        for (int c = 0; c < 12; c++) begin
            i_ld_valid = (w < 4) && (c % 3 != 1);
            i_ld_data  = (w < 4) ? words[w] : 32'd0;
            i_ld_last  = (w == 3);
            @(negedge i_clk);
            exp_wr = i_ld_valid;
            if (exp_wr) exp_q.push_back({32'(w * 4), words[w]});
            total_cnt++; if (a_imem_write !== exp_wr) $display("FAIL load_write_strobe cyc=%0d got %b want %b", c, a_imem_write, exp_wr); else pass_cnt++;
            if (a_imem_write === 1'b1) begin
                writes++;
                total_cnt++;
                if (exp_q.size() == 0) $display("FAIL load_unexpected_write addr=%h", a_imem_waddr);
                else begin
                    e = exp_q.pop_front();
                    if ({a_imem_waddr, a_imem_wdata} !== e) $display("FAIL load_write addr/data got %h/%h want %h/%h", a_imem_waddr, a_imem_wdata, e[63:32], e[31:0]);
                    else pass_cnt++;
                end
            end
            if (a_load_done === 1'b1) done_seen++;
            if (exp_wr) w++;
            @(posedge i_clk); #1;
        end
        clear_inputs();
        total_cnt++; if (writes != 4 || exp_q.size() != 0) $display("FAIL load_write_total got %0d pending %0d want 4/0", writes, exp_q.size()); else pass_cnt++;
        total_cnt++; if (done_seen != 1) $display("FAIL load_done_pulses got %0d want 1", done_seen); else pass_cnt++;
        total_cnt++; if (a_word_count !== 9'd4 || a_state !== 3'd0) $display("FAIL load_end count=%0d state=%0d want 4/0", a_word_count, a_state); else pass_cnt++;
    endtask

    task automatic test_load_limit();
        int  mcnt = 0, done_seen = 0, writes = 0;
        bit  exp_rdy;
        logic [63:0] e;
        apply_reset();
        exp_q.delete();
        i_load_start = 1;
        @(posedge i_clk); #1 i_load_start = 0;
        for (int c = 0; c < 6; c++) begin
            i_ld_valid = 1;
            i_ld_data  = 32'h100 + 32'(c);
            @(negedge i_clk);
            exp_rdy = (mcnt < 4);
            if (exp_rdy) exp_q.push_back({32'(mcnt * 4), i_ld_data});
            total_cnt++; if (b_ld_ready !== exp_rdy || b_imem_write !== exp_rdy) $display("FAIL limit_ready cyc=%0d ready=%b write=%b want %b", c, b_ld_ready, b_imem_write, exp_rdy); else pass_cnt++;
            if (b_imem_write === 1'b1) begin
                writes++;
                total_cnt++;
                if (exp_q.size() == 0) $display("FAIL limit_unexpected_write addr=%h", b_imem_waddr);
                else begin
                    e = exp_q.pop_front();
                    if ({b_imem_waddr, b_imem_wdata} !== e) $display("FAIL limit_write addr/data got %h/%h want %h/%h", b_imem_waddr, b_imem_wdata, e[63:32], e[31:0]);
                    else pass_cnt++;
                end
            end
            if (b_load_done === 1'b1) done_seen++;
            if (exp_rdy) mcnt++;
            @(posedge i_clk); #1;
        end
        clear_inputs();
        total_cnt++; if (writes != 4 || done_seen != 1) $display("FAIL limit_totals writes=%0d done=%0d want 4/1", writes, done_seen); else pass_cnt++;
        total_cnt++; if (b_state !== 3'd0 || b_word_count !== 3'd4) $display("FAIL limit_end state=%0d count=%0d want 0/4", b_state, b_word_count); else pass_cnt++;
    endtask

    task automatic test_stall();
        int stalled = 0;
        enter_run();
        for (int c = 0; c < 6; c++) begin
            i_stall = (c == 2 || c == 3);
            @(negedge i_clk);
            total_cnt++;
            if (a_pc_en !== !i_stall || a_ifid_en !== !i_stall || a_imem_read !== 1'b1)
                $display("FAIL stall cyc=%0d pc_en=%b ifid_en=%b read=%b want %b/%b/1", c, a_pc_en, a_ifid_en, a_imem_read, !i_stall, !i_stall);
            else pass_cnt++;
            if (a_pc_en === 1'b0) stalled++;
            @(posedge i_clk); #1;
        end
        clear_inputs();
        total_cnt++; if (stalled != 2) $display("FAIL stall_len got %0d want 2", stalled); else pass_cnt++;
    endtask

    task automatic test_redirect();
        enter_run();
        i_branch = 1; i_zero = 1; i_stall = 1;
        @(negedge i_clk);
        total_cnt++;
        if ({a_pc_en, a_ifid_flush, a_ifid_en} !== 3'b110) $display("FAIL redirect_taken pc/flush/ifid got %b want 110", {a_pc_en, a_ifid_flush, a_ifid_en}); else pass_cnt++;
        @(posedge i_clk); #1;
        i_zero = 0; i_stall = 0;
        @(negedge i_clk);
        total_cnt++;
        if ({a_pc_en, a_ifid_flush, a_ifid_en, a_state} !== 6'b101_010) $display("FAIL redirect_not_taken pc/flush/ifid/state got %b want 101010", {a_pc_en, a_ifid_flush, a_ifid_en, a_state}); else pass_cnt++;
        @(posedge i_clk); #1;
        i_branch = 0; i_jump = 1;
        @(negedge i_clk);
        total_cnt++; if (a_ifid_flush !== 1'b1 || a_pc_en !== 1'b1) $display("FAIL redirect_jump flush=%b pc_en=%b want 1/1", a_ifid_flush, a_pc_en); else pass_cnt++;
        clear_inputs();
    endtask

    task automatic test_flush_len();
        int flushes = 0;
        enter_run();
        for (int c = 0; c < 4; c++) begin
            i_jump = (c == 0);
            @(negedge i_clk);
            if (b_ifid_flush === 1'b1) flushes++;
            @(posedge i_clk); #1;
        end
        clear_inputs();
        total_cnt++; if (flushes != 2 || b_state !== 3'd2) $display("FAIL flush_len flushes=%0d state=%0d want 2/2", flushes, b_state); else pass_cnt++;
    endtask

    task automatic test_redirect_halt();
        int flushes = 0;
        enter_run();
        i_jump = 1;
        @(negedge i_clk);
        if (b_ifid_flush === 1'b1) flushes++;
        @(posedge i_clk); #1;
        i_jump = 0; i_halt = 1;
        @(negedge i_clk);
        total_cnt++; if (b_state !== 3'd3) $display("FAIL halt_in_redirect state got %0d want 3", b_state); else pass_cnt++;
        if (b_ifid_flush === 1'b1) flushes++;
        @(posedge i_clk); #1;
        i_halt = 0;
        @(negedge i_clk);
        if (b_ifid_flush === 1'b1) flushes++;
        total_cnt++; if (flushes != 1) $display("FAIL halt_flush_cycles got %0d want 1", flushes); else pass_cnt++;
        total_cnt++;
        if ({b_state, b_pc_en, b_imem_read} !== 5'b100_00) $display("FAIL halt_outputs state=%0d pc_en=%b read=%b want 4/0/0", b_state, b_pc_en, b_imem_read); else pass_cnt++;
        @(posedge i_clk); #1 i_run = 1;
        @(posedge i_clk); #1 i_run = 0;
        @(negedge i_clk);
        total_cnt++; if (b_state !== 3'd2 || b_imem_read !== 1'b1) $display("FAIL halt_resume state=%0d read=%b want 2/1", b_state, b_imem_read); else pass_cnt++;
        clear_inputs();
    endtask

    initial begin
        test_reset();
        test_load();
        test_load_limit();
        test_stall();
        test_redirect();
        test_flush_len();
        test_redirect_halt();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
